// File: rtl/uc_pkg.sv
// Shared encodings for the unidade_controle fetch/decode unit: RV64 opcode fields,
// the ECALL word, FSM state codes and the registered datapath control bundle.
package uc_pkg;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [2:0]  F3_DWORD   = 3'b011;
    localparam logic [2:0]  F3_ADDSUB  = 3'b000;
    localparam logic [6:0]  F7_ADD     = 7'b0000000;
    localparam logic [6:0]  F7_SUB     = 7'b0100000;
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_DECODE = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    typedef struct packed {
        logic load_store;
        logic op_ula;
        logic operation_type;
        logic ula_entry;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '{load_store: 1'b0, op_ula: 1'b0,
                                    operation_type: 1'b0, ula_entry: 1'b0};

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Purely combinational decoder: one instruction word to datapath controls,
// register fields, sign-extended immediate and legal/ecall classification.
module decodificador
    import uc_pkg::*;
#(
    parameter int BITS = 63
) (
    input  logic [31:0]   instr,
    output logic [4:0]    ra,
    output logic [4:0]    rb,
    output logic [4:0]    rw,
    output logic [BITS:0] imm,
    output logic          load_store,
    output logic          op_ula,
    output logic          operation_type,
    output logic          ula_entry,
    output logic          legal,
    output logic          ecall
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [11:0] imm12_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign ecall    = (instr == ECALL_WORD);
    assign imm      = {{(BITS - 10){imm12_s[11]}}, imm12_s[10:0]};

    // Classify the word and select controls; anything unmatched stays illegal.
    always_comb begin
        ra             = instr[24:20];
        rb             = instr[19:15];
        rw             = instr[11:7];
        imm12_s        = 12'h000;
        load_store     = 1'b0;
        op_ula         = 1'b0;
        operation_type = 1'b0;
        ula_entry      = 1'b0;
        legal          = 1'b0;
        case (opcode_s)
            OPC_LOAD: begin
                if (funct3_s == F3_DWORD) begin
                    legal      = 1'b1;
                    load_store = 1'b1;
                    op_ula     = 1'b1;
                    imm12_s    = instr[31:20];
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_STORE: begin
                if (funct3_s == F3_DWORD) begin
                    legal   = 1'b1;
                    op_ula  = 1'b1;
                    rw      = 5'd0;
                    imm12_s = {instr[31:25], instr[11:7]};
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP: begin
                if ((funct3_s == F3_ADDSUB) && (funct7_s == F7_ADD)) begin
                    legal          = 1'b1;
                    load_store     = 1'b1;
                    op_ula         = 1'b1;
                    operation_type = 1'b1;
                    ula_entry      = 1'b1;
                end else if ((funct3_s == F3_ADDSUB) && (funct7_s == F7_SUB)) begin
                    legal          = 1'b1;
                    load_store     = 1'b1;
                    op_ula         = 1'b0;
                    operation_type = 1'b1;
                    ula_entry      = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle FETCH/WAIT/DECODE/EXEC control unit driving the load/store/add/sub
// datapath; every output is a flop, so imem_data and start never reach outputs directly.
module unidade_controle
    import uc_pkg::*;
#(
    parameter int BITS     = 63,
    parameter int PC_BITS  = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic [PC_BITS-1:0]  imem_addr,
    output logic                imem_en,
    input  logic [31:0]         imem_data,
    output logic                enable,
    output logic [4:0]          ra,
    output logic [4:0]          rb,
    output logic [4:0]          rw,
    output logic [BITS:0]       dataIn,
    output logic                load_store,
    output logic                op_ula,
    output logic                operation_type,
    output logic                ula_entry,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_BITS-1:0] instr_count
);

    localparam logic [PC_BITS-1:0]  PC_ZERO  = {PC_BITS{1'b0}};
    localparam logic [PC_BITS-1:0]  PC_STEP  = PC_BITS'(3'd4);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1'b1);

    state_t                state_q, state_d;
    logic [PC_BITS-1:0]    pc_q, pc_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [31:0]           ir_q, ir_d;
    logic [4:0]            ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
    logic [BITS:0]         imm_q, imm_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  imem_en_q, imem_en_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;

    logic [4:0]    dec_ra_s, dec_rb_s, dec_rw_s;
    logic [BITS:0] dec_imm_s;
    ctrl_t         dec_ctrl_s;
    logic          dec_legal_s, dec_ecall_s;

    decodificador #(.BITS(BITS)) u_dec (
        .instr          (ir_q),
        .ra             (dec_ra_s),
        .rb             (dec_rb_s),
        .rw             (dec_rw_s),
        .imm            (dec_imm_s),
        .load_store     (dec_ctrl_s.load_store),
        .op_ula         (dec_ctrl_s.op_ula),
        .operation_type (dec_ctrl_s.operation_type),
        .ula_entry      (dec_ctrl_s.ula_entry),
        .legal          (dec_legal_s),
        .ecall          (dec_ecall_s)
    );

    // Next-state, PC/counter and datapath-output update; status flags follow state_d
    // so that their registered copies line up with the state being entered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rw_d    = rw_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = PC_ZERO;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_legal_s) begin
                    ra_d    = dec_ra_s;
                    rb_d    = dec_rb_s;
                    rw_d    = dec_rw_s;
                    imm_d   = dec_imm_s;
                    ctrl_d  = dec_ctrl_s;
                    state_d = ST_EXEC;
                end else if (dec_ecall_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_EXEC: begin
                pc_d    = pc_q + PC_STEP;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = ST_FETCH;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
        imem_en_d = (state_d == ST_FETCH);
        enable_d  = (state_d == ST_EXEC);
        busy_d    = (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                    (state_d == ST_DECODE) || (state_d == ST_EXEC);
        halted_d  = (state_d == ST_HALT);
        illegal_d = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_ZERO;
            cnt_q     <= CNT_ZERO;
            ir_q      <= 32'h0000_0000;
            ra_q      <= 5'd0;
            rb_q      <= 5'd0;
            rw_q      <= 5'd0;
            imm_q     <= {(BITS + 1){1'b0}};
            ctrl_q    <= CTRL_ZERO;
            imem_en_q <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rw_q      <= rw_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            imem_en_q <= imem_en_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr      = pc_q;
    assign imem_en        = imem_en_q;
    assign enable         = enable_q;
    assign ra             = ra_q;
    assign rb             = rb_q;
    assign rw             = rw_q;
    assign dataIn         = imm_q;
    assign load_store     = ctrl_q.load_store;
    assign op_ula         = ctrl_q.op_ula;
    assign operation_type = ctrl_q.operation_type;
    assign ula_entry      = ctrl_q.ula_entry;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign illegal        = illegal_q;
    assign instr_count    = cnt_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle (PC_BITS=4, so the 16-byte program wraps);
// expected values come from instruction kind/fields/immediate chosen by the bench.
module tb_unidade_controle;

    localparam int BITS     = 63;
    localparam int PC_BITS  = 4;
    localparam int CNT_BITS = 16;

    localparam int K_LD = 0, K_SD = 1, K_ADD = 2, K_SUB = 3, K_ECALL = 4, K_ILL = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic [PC_BITS-1:0]  imem_addr;
    logic                imem_en;
    logic [31:0]         imem_data = 32'h0;
    logic                enable;
    logic [4:0]          ra, rb, rw;
    logic [BITS:0]       dataIn;
    logic                load_store, op_ula, operation_type, ula_entry;
    logic                busy, halted, illegal;
    logic [CNT_BITS-1:0] instr_count;

    logic [31:0] imem [0:3];

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_pc;
    logic [15:0] exp_cnt;
    logic [4:0]  h_ra, h_rb, h_rw;
    logic [63:0] h_din;
    logic        h_ls, h_op, h_ot, h_ue;

    unidade_controle #(.BITS(BITS), .PC_BITS(PC_BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .enable(enable), .ra(ra), .rb(rb), .rw(rw), .dataIn(dataIn),
        .load_store(load_store), .op_ula(op_ula), .operation_type(operation_type),
        .ula_entry(ula_entry), .busy(busy), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word appears the cycle after imem_en.
    always @(posedge clk) begin
        if (imem_en) imem_data <= imem[imem_addr[3:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_pc = 4'd0; exp_cnt = 16'd0;
        h_ra = 5'd0; h_rb = 5'd0; h_rw = 5'd0; h_din = 64'd0;
        h_ls = 1'b0; h_op = 1'b0; h_ot = 1'b0; h_ue = 1'b0;
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_rw"}, rw, h_rw);
        chk({tag, "_din"}, dataIn, h_din);
        chk({tag, "_ctrl"}, {load_store, op_ula, operation_type, ula_entry},
            {h_ls, h_op, h_ot, h_ue});
    endtask

    // Called just after a negedge; leaves the DUT in IDLE.
    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
    endtask

    task automatic start_prog(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        exp_pc = 4'd0;
        exp_cnt = 16'd0;
    endtask

    function automatic logic [31:0] enc(input int kind, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input int imm);
        logic [11:0] i12;
        i12 = imm[11:0];
        case (kind)
            K_LD:    enc = {i12, rs1, 3'b011, rd, 7'b0000011};
            K_SD:    enc = {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'b0100011};
            K_ADD:   enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        endcase
    endfunction

    // Entered at the negedge of a FETCH cycle; runs one instruction through the FSM.
    task automatic do_instr(input logic [31:0] w, input int kind, input int imm,
                            input bit rst_exec);
        logic [4:0]  e_ra, e_rb, e_rw;
        logic [63:0] e_din;
        imem[exp_pc[3:2]] = w;
        chk("fetch_en", imem_en, 64'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_busy", busy, 64'd1);
        chk("fetch_count", instr_count, exp_cnt);
        chk("fetch_enable", enable, 64'd0);
        @(negedge clk);
        chk("wait_en", imem_en, 64'd0);
        chk("wait_enable", enable, 64'd0);
        @(negedge clk);
        chk("decode_enable", enable, 64'd0);
        check_held("decode_hold");
        @(negedge clk);
        if (kind <= K_SUB) begin
            e_ra  = w[24:20];
            e_rb  = w[19:15];
            e_rw  = (kind == K_SD) ? 5'd0 : w[11:7];
            e_din = (kind <= K_SD) ? 64'(longint'(imm)) : 64'd0;
            h_ls = (kind != K_SD);
            h_op = (kind != K_SUB);
            h_ot = (kind >= K_ADD);
            h_ue = (kind >= K_ADD);
            h_ra = e_ra; h_rb = e_rb; h_rw = e_rw; h_din = e_din;
            chk("exec_enable", enable, 64'd1);
            chk("exec_busy", busy, 64'd1);
            chk("exec_ra", ra, e_ra);
            chk("exec_rb", rb, e_rb);
            check_held("exec");
            if (rst_exec) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk("rst_enable", enable, 64'd0);
                chk("rst_addr", imem_addr, 64'd0);
                chk("rst_busy", busy, 64'd0);
                chk("rst_count", instr_count, 64'd0);
                chk("rst_din", dataIn, 64'd0);
                chk("rst_ls", load_store, 64'd0);
                reset_n = 1'b1;
                clear_model();
            end else begin
                exp_pc = exp_pc + 4'd4;
                exp_cnt = exp_cnt + 16'd1;
                @(negedge clk);
                chk("post_enable", enable, 64'd0);
                chk("post_ra", ra, h_ra);
                check_held("post_hold");
            end
        end else if (kind == K_ECALL) begin
            chk("halt_halted", halted, 64'd1);
            chk("halt_busy", busy, 64'd0);
            chk("halt_enable", enable, 64'd0);
            chk("halt_count", instr_count, exp_cnt);
        end else begin
            chk("err_illegal", illegal, 64'd1);
            chk("err_busy", busy, 64'd0);
            chk("err_enable", enable, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        int kind, imm;
        logic [31:0] ill_words [0:4];

        clear_model();
        imem[0] = 32'h0; imem[1] = 32'h0; imem[2] = 32'h0; imem[3] = 32'h0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {enable, imem_en, busy, halted, illegal, load_store, op_ula, operation_type, ula_entry},
            64'd0);
        chk("reset_regs", {ra, rb, rw}, 64'd0);
        chk("reset_din", dataIn, 64'd0);
        chk("reset_count", instr_count, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 64'd0);

        // Directed program; start stays high through the first instruction.
        start_prog(1'b1);
        do_instr(32'h0081_3283, K_LD, 8, 1'b0);
        start = 1'b0;
        do_instr(32'hFE51_3C23, K_SD, -8, 1'b0);
        do_instr(32'h4062_83B3, K_SUB, 0, 1'b0);
        do_instr(32'h0000_0073, K_ECALL, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("halt_stays", halted, 64'd1);
        chk("halt_no_fetch", imem_en, 64'd0);
        chk("halt_count3", instr_count, 64'd3);

        // Restart from HALT, then a random program long enough to wrap the PC.
        start_prog(1'b0);
        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 3);
            imm  = int'($urandom_range(0, 4095)) - 2048;
            w    = enc(kind, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), imm);
            do_instr(w, kind, imm, 1'b0);
        end
        do_instr(32'h0000_0073, K_ECALL, 0, 1'b0);

        // Reset beats start while halted.
        start = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_vs_start_halted", halted, 64'd0);
        chk("rst_vs_start_busy", busy, 64'd0);
        chk("rst_vs_start_en", imem_en, 64'd0);
        start = 1'b0;
        reset_n = 1'b1;
        clear_model();
        @(negedge clk);

        // Reset during EXEC of the third instruction.
        start_prog(1'b0);
        do_instr(enc(K_ADD, 5'd1, 5'd2, 5'd3, 0), K_ADD, 0, 1'b0);
        do_instr(enc(K_LD, 5'd9, 5'd4, 5'd0, -1), K_LD, -1, 1'b0);
        do_instr(enc(K_SD, 5'd0, 5'd7, 5'd8, 2047), K_SD, 2047, 1'b1);
        @(negedge clk);
        chk("after_rst_idle", busy, 64'd0);

        // Unsupported encodings land in ERROR; start is ignored there.
        ill_words[0] = 32'h0000_0000;
        ill_words[1] = 32'h0262_83B3;
        ill_words[2] = 32'h0081_2283;
        ill_words[3] = 32'h0010_0073;
        ill_words[4] = {$urandom} | 32'h0000_007F;
        for (int i = 0; i < 5; i++) begin
            start_prog(1'b0);
            do_instr(ill_words[i], K_ILL, 0, 1'b0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("err_sticky", illegal, 64'd1);
            chk("err_ignores_start", {busy, imem_en}, 64'd0);
            do_reset();
            chk("err_cleared", illegal, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
